sync_fifo_wr_arb: RTL and testbench
===================================

Name: sync_fifo_wr_arb

Overview:
Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST words, then drives the FIFO's write enable and data. It sits directly in front of a sync_fifo instance and consumes that FIFO's full flag.

Parameters:
- WIDTH, 19, data word width; must match the downstream sync_fifo WIDTH.
- NUM_REQ, 4, number of producers; legal range 2..16.
- MAX_BURST, 8, maximum words accepted per grant before forced rotation; legal range 1..256.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_req_valid  in  NUM_REQ  per-producer valid.
- i_req_data  in  NUM_REQ*WIDTH  producer data, flattened; producer k occupies bits [k*WIDTH +: WIDTH].
- o_req_ready  out  NUM_REQ  per-producer ready; at most one bit high.
- o_fifo_data  out  WIDTH  to sync_fifo i_data.
- o_fifo_wr_en  out  1  to sync_fifo i_wr_en.
- i_fifo_full  in  1  from sync_fifo o_full.
- o_grant  out  NUM_REQ  registered one-hot grant; all-zero when idle.
- o_busy  out  1  high while in BURST.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, o_grant=0, burst_cnt=0, last_grant=NUM_REQ-1, so the first search starts at producer 0.
  - o_req_ready, o_fifo_wr_en and o_busy are 0.
  - o_fifo_data is 0 while o_grant=0.
- States: IDLE, BURST.
- IDLE:
  - If any i_req_valid bit is set, select the first valid index scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - Register the selection into o_grant and last_grant, clear burst_cnt, and go to BURST.
  - Arbitration costs exactly 1 cycle; no transfer occurs in IDLE.
- BURST, granted index g:
  - Combinational outputs:
    - o_req_ready[g] = !i_fifo_full.
    - o_fifo_wr_en = i_req_valid[g] & !i_fifo_full.
    - o_fifo_data = i_req_data[g] whenever o_grant is nonzero.
  - A transfer is a cycle with o_fifo_wr_en=1. Each transfer increments burst_cnt.
  - Exit to IDLE (o_grant cleared the next cycle) when either:
    - a transfer occurs with burst_cnt==MAX_BURST-1, or
    - i_req_valid[g]==0 in a cycle with no transfer (producer released).
  - While i_fifo_full=1, no transfer occurs and state holds, even if i_req_valid[g] drops. A drop while full counts as release on the next non-full cycle.
  - Otherwise the state remains BURST.
- Fairness: last_grant advances only on a new grant. A producer continuously valid waits at most (NUM_REQ-1) bursts plus (NUM_REQ-1) arbitration cycles.
- Full boundary: the write path is combinational from i_fifo_full, so no write is issued in any cycle full=1. The FIFO can never overflow through this block.
- Non-granted producers: o_req_ready is always 0; their data and valid are ignored.
- Producer contract: a valid producer must hold data stable until ready.
- Reset mid-burst: immediate return to the reset values above. A partially transferred burst is not resumed.
- burst_cnt width is clog2(MAX_BURST)+1 bits; it never wraps because the exit fires at MAX_BURST-1.

Optional Feature:
- Macro: SYNC_FIFO_WR_ARB_STATS_EN.
- When defined, adds output o_stall_cnt (16 bits). It increments each cycle state==BURST & i_req_valid[g] & i_fifo_full.
  - Saturates at 16'hFFFF.
  - Reset to 0.
  - Adds input i_stall_clr (1 bit), a synchronous clear that takes priority over increment.
- When undefined, neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset/idle: hold i_rst 100ns with all valid=0 -> o_grant=0, o_fifo_wr_en=0, o_busy=0, o_req_ready=0 for 10 cycles after release.
- Single producer: producer 2 valid with data 0x00..0x09 streamed, FIFO never full, MAX_BURST=8:
  - grant 4'b0100 one cycle after valid; 8 back-to-back writes; 1 IDLE cycle; regrant 2; 2 more writes.
  - Downstream FIFO reads 0x00..0x09 in order.
- Round-robin: all 4 producers continuously valid, each sending 16 words tagged {id,seq}:
  - Grant order 0,1,2,3,0,1,2,3.
  - Each burst is exactly 8 writes.
  - FIFO readback shows per-producer seq strictly increasing.
- Backpressure: fill a DEPTH=128 FIFO through producer 0; producer 1 keeps valid high:
  - o_fifo_wr_en=0 and o_req_ready=0 while full.
  - After draining 1 word, exactly 1 write occurs.
  - No overflow; total 128 words stored.
- Early release: producer 3 sends 3 words, then drops valid:
  - Return to IDLE after the 3rd transfer plus 1 cycle.
  - Next grant goes to the lowest valid index scanning from 0 (wrap).
- Reset mid-burst: assert i_rst after 4 of 8 words from producer 1:
  - Outputs go to reset values immediately (before the next clock edge).
  - After release, the first grant goes to producer 0 if it is valid.

Source files
------------

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin burst arbiter sharing one sync_fifo write port among NUM_REQ producers
// Ports: i_clk, i_rst (async active-high); i_req_valid/i_req_data/o_req_ready per-producer handshake,
// data flattened with producer k at [k*WIDTH +: WIDTH]; o_fifo_data/o_fifo_wr_en/i_fifo_full to sync_fifo;
// o_grant registered one-hot grant, o_busy high in BURST.
// Optional SYNC_FIFO_WR_ARB_STATS_EN adds i_stall_clr and saturating 16-bit o_stall_cnt.
module sync_fifo_wr_arb #(
  parameter int WIDTH = 19,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]         o_fifo_data,
  output logic                     o_fifo_wr_en,
  input  logic                     i_fifo_full,
  output logic [NUM_REQ-1:0]       o_grant,
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  input  logic                     i_stall_clr,
  output logic [15:0]              o_stall_cnt,
`endif
  output logic                     o_busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IW-1:0] last_grant, last_nxt, sel, cand;
  logic [CW-1:0] burst_cnt, cnt_nxt;
  logic found;
  logic g_valid;
  // last_grant doubles as the granted index while in BURST
  assign g_valid = i_req_valid[last_grant];
  always_comb begin
    sel = '0;
    found = 1'b0;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && i_req_valid[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_grant <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      o_grant <= grant_nxt;
      last_grant <= last_nxt;
      burst_cnt <= cnt_nxt;
    end
  end
  // a full FIFO freezes the burst; a valid drop only counts as release once not full
  always_comb begin
    state_nxt = state;
    grant_nxt = o_grant;
    last_nxt = last_grant;
    cnt_nxt = burst_cnt;
    if (state == IDLE) begin
      if (found) begin
        state_nxt = BURST;
        grant_nxt = NUM_REQ'(1) << sel;
        last_nxt = sel;
        cnt_nxt = '0;
      end
    end else if (o_fifo_wr_en) begin
      cnt_nxt = burst_cnt + 1'b1;
      if (burst_cnt == CW'(MAX_BURST - 1)) begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    end else if (!i_fifo_full && !g_valid) begin
      state_nxt = IDLE;
      grant_nxt = '0;
    end
  end
  always_comb begin
    o_busy = state == BURST;
    o_fifo_wr_en = o_busy && g_valid && !i_fifo_full;
    o_req_ready = o_busy ? {{(NUM_REQ-1){1'b0}}, !i_fifo_full} << last_grant : '0;
    o_fifo_data = |o_grant ? i_req_data[int'(last_grant)*WIDTH +: WIDTH] : '0;
  end
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_stall_cnt <= '0;
    else if (i_stall_clr) o_stall_cnt <= '0;
    else if (o_busy && g_valid && i_fifo_full && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// tb_sync_fifo_wr_arb: directed table and sequence checks for sync_fifo_wr_arb
module tb_sync_fifo_wr_arb;
  localparam int W = 19;
  localparam int N = 4;
  localparam logic [W-1:0] D0 = 19'h11111, D1 = 19'h22222, D2 = 19'h33333, D3 = 19'h44444;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_fifo_full = 1'b0;
  logic [N-1:0] i_req_valid = '0;
  logic [N*W-1:0] i_req_data = '0;
  logic [N-1:0] o_req_ready, o_grant;
  logic [W-1:0] o_fifo_data;
  logic o_fifo_wr_en, o_busy;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  logic i_stall_clr = 1'b0;
  logic [15:0] o_stall_cnt;
`endif
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] v;
    logic f;
    logic [3:0] g;
    logic [3:0] r;
    logic wr;
    logic b;
    logic [W-1:0] d;
  } vec_t;
  vec_t tv[16];
  sync_fifo_wr_arb #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(8)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req_valid(i_req_valid),
    .i_req_data(i_req_data),
    .o_req_ready(o_req_ready),
    .o_fifo_data(o_fifo_data),
    .o_fifo_wr_en(o_fifo_wr_en),
    .i_fifo_full(i_fifo_full),
    .o_grant(o_grant),
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    .i_stall_clr(i_stall_clr),
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic do_reset;
    i_rst = 1'b1;
    i_req_valid = '0;
    i_fifo_full = 1'b0;
    #100;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask
  function automatic vec_t mk(logic [3:0] v, logic f, logic [3:0] g, logic [3:0] r, logic wr, logic b, logic [W-1:0] d);
    vec_t t;
    t.v = v; t.f = f; t.g = g; t.r = r; t.wr = wr; t.b = b; t.d = d;
    return t;
  endfunction
  initial begin
    int seq, n, occ, wrs, nb, bw, g;
    int s[N];
    logic [13:0] pat;
    logic [N-1:0] prev;
    tv[0]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, '0);
    tv[1]  = mk(4'b0100, 0, 4'b0000, 4'b0000, 0, 0, '0);
    tv[2]  = mk(4'b0100, 0, 4'b0100, 4'b0100, 1, 1, D2);
    tv[3]  = mk(4'b0100, 1, 4'b0100, 4'b0000, 0, 1, D2);
    tv[4]  = mk(4'b0000, 1, 4'b0100, 4'b0000, 0, 1, D2);
    tv[5]  = mk(4'b0000, 0, 4'b0100, 4'b0100, 0, 1, D2);
    tv[6]  = mk(4'b1011, 0, 4'b0000, 4'b0000, 0, 0, '0);
    tv[7]  = mk(4'b1011, 0, 4'b1000, 4'b1000, 1, 1, D3);
    tv[8]  = mk(4'b0011, 0, 4'b1000, 4'b1000, 0, 1, D3);
    tv[9]  = mk(4'b0011, 0, 4'b0000, 4'b0000, 0, 0, '0);
    tv[10] = mk(4'b0011, 0, 4'b0001, 4'b0001, 1, 1, D0);
    tv[11] = mk(4'b0010, 0, 4'b0001, 4'b0001, 0, 1, D0);
    tv[12] = mk(4'b0010, 0, 4'b0000, 4'b0000, 0, 0, '0);
    tv[13] = mk(4'b0010, 0, 4'b0010, 4'b0010, 1, 1, D1);
    tv[14] = mk(4'b0000, 0, 4'b0010, 4'b0010, 0, 1, D1);
    tv[15] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, '0);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk); #1;
      chk("rst_grant", o_grant, 0);
      chk("rst_wr", o_fifo_wr_en, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_req_ready, 0);
    end
    i_req_data = {D3, D2, D1, D0};
    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      i_req_valid = tv[i].v;
      i_fifo_full = tv[i].f;
      #1;
      chk($sformatf("tv%0d_grant", i), o_grant, tv[i].g);
      chk($sformatf("tv%0d_ready", i), o_req_ready, tv[i].r);
      chk($sformatf("tv%0d_wr", i), o_fifo_wr_en, tv[i].wr);
      chk($sformatf("tv%0d_busy", i), o_busy, tv[i].b);
      chk($sformatf("tv%0d_data", i), o_fifo_data, tv[i].d);
    end
    seq = 0;
    pat = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge i_clk);
      i_req_valid = (seq < 10) ? 4'b0100 : 4'b0000;
      i_req_data[2*W +: W] = W'(seq);
      #1;
      if (c == 1 || c == 10) chk("single_grant", o_grant, 4'b0100);
      if (c == 9) chk("single_idle", o_grant, 0);
      pat[c] = o_fifo_wr_en;
      if (o_fifo_wr_en) begin
        chk("single_data", o_fifo_data, seq);
        seq++;
      end
    end
    chk("single_pattern", pat, 14'b00_1101_1111_1110);
    chk("single_count", seq, 10);
    do_reset();
    for (int k = 0; k < N; k++) s[k] = 0;
    prev = '0;
    nb = 0;
    bw = 0;
    for (int c = 0; c < 72; c++) begin
      @(negedge i_clk);
      for (int k = 0; k < N; k++) i_req_data[k*W +: W] = {k[1:0], 17'(s[k])};
      i_req_valid = 4'b1111;
      #1;
      if (o_grant != 0 && prev == 0) begin
        if (nb > 0) chk("rr_len", bw, 8);
        chk("rr_order", o_grant, 4'b1 << (nb % 4));
        nb++;
        bw = 0;
      end
      prev = o_grant;
      if (o_fifo_wr_en) begin
        g = 0;
        for (int k = 0; k < N; k++) if (o_grant[k]) g = k;
        chk("rr_data", o_fifo_data, {g[1:0], 17'(s[g])});
        s[g]++;
        bw++;
      end
    end
    chk("rr_len", bw, 8);
    chk("rr_bursts", nb, 8);
    do_reset();
    occ = 0;
    i_req_valid = 4'b0011;
    for (int c = 0; c < 400 && occ < 128; c++) begin
      @(negedge i_clk);
      i_fifo_full = 1'b0;
      #1;
      if (o_fifo_wr_en) occ++;
    end
    chk("bp_fill", occ, 128);
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      i_fifo_full = (occ >= 128);
      #1;
      chk("bp_full_wr", o_fifo_wr_en, 0);
      chk("bp_full_ready", o_req_ready, 0);
      if (o_fifo_wr_en) occ++;
    end
    occ--;
    wrs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      i_fifo_full = (occ >= 128);
      #1;
      if (o_fifo_wr_en) begin
        occ++;
        wrs++;
      end
    end
    chk("bp_drain_writes", wrs, 1);
    chk("bp_stored", occ, 128);
    do_reset();
    i_req_data = {D3, D2, D1, D0};
    i_req_valid = 4'b1000;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge i_clk); #1;
      if (o_fifo_wr_en) n++;
    end
    @(negedge i_clk);
    i_req_valid = 4'b0110;
    #1;
    chk("er_release_busy", o_busy, 1);
    chk("er_release_wr", o_fifo_wr_en, 0);
    @(negedge i_clk); #1;
    chk("er_idle_busy", o_busy, 0);
    chk("er_idle_grant", o_grant, 0);
    @(negedge i_clk); #1;
    chk("er_wrap_grant", o_grant, 4'b0010);
    do_reset();
    i_req_valid = 4'b0010;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge i_clk); #1;
      if (o_fifo_wr_en) n++;
    end
    @(posedge i_clk); #2;
    chk("mr_busy_pre", o_busy, 1);
    i_rst = 1'b1;
    #1;
    chk("mr_grant", o_grant, 0);
    chk("mr_busy", o_busy, 0);
    chk("mr_ready", o_req_ready, 0);
    chk("mr_wr", o_fifo_wr_en, 0);
    chk("mr_data", o_fifo_data, 0);
    i_req_valid = 4'b0011;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk); #1;
    chk("mr_regrant", o_grant, 4'b0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
